// File: rtl/wb_arbiter.sv
// wb_arbiter: pipelined Wishbone B4 arbiter, LSM (m0) and fetch (m1) onto one slave.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin arbitration instead of m0 > m1.
module wb_arbiter #(
  parameter int unsigned OUTST_W = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_stall_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_stall_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_stall_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_M0,
    GRANT_M1
  } state_t;

  state_t             state;
  logic [1:0]         grant_q;
  logic [OUTST_W-1:0] outst;

  logic own0, own1;
  logic cur_cyc, cur_stb;
  logic full, pending;
  logic accept, retire, release_ok;
  logic pick0, pick1;

  assign own0 = (state == GRANT_M0);
  assign own1 = (state == GRANT_M1);

  assign cur_cyc = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
  assign cur_stb = (own0 & m0_stb_i) | (own1 & m1_stb_i);

  assign full    = &outst;
  assign pending = |outst;

  // cyc stays up while acks are owed, even if the master let go early
  assign s_cyc_o = (own0 | own1) & (cur_cyc | pending);
  assign s_stb_o = cur_stb & ~full;
  assign s_adr_o = own0 ? m0_adr_i : (own1 ? m1_adr_i : '0);
  assign s_dat_o = own0 ? m0_dat_i : (own1 ? m1_dat_i : '0);
  assign s_we_o  = (own0 & m0_we_i) | (own1 & m1_we_i);
  assign s_sel_o = own0 ? m0_sel_i : (own1 ? m1_sel_i : '0);

  assign m0_stall_o = ~own0 | s_stall_i | full;
  assign m0_ack_o   = own0 & s_ack_i;
  assign m0_dat_o   = own0 ? s_dat_i : '0;
  assign m1_stall_o = ~own1 | s_stall_i | full;
  assign m1_ack_o   = own1 & s_ack_i;
  assign m1_dat_o   = own1 ? s_dat_i : '0;

  assign grant_o = grant_q;

  assign accept     = s_stb_o & ~s_stall_i;
  assign retire     = s_ack_i & pending;
  assign release_ok = ~cur_cyc
                    & (~pending | ((outst == OUTST_W'(1)) & s_ack_i));

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic last_m1;
  assign pick0 = m0_cyc_i & (~m1_cyc_i | last_m1);
`else
  assign pick0 = m0_cyc_i;
`endif
  assign pick1 = m1_cyc_i & ~pick0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      grant_q <= 2'b00;
      outst   <= '0;
`ifdef WB_ARB_ROUND_ROBIN_EN
      last_m1 <= 1'b1;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          outst <= '0;
          if (pick0) begin
            state   <= GRANT_M0;
            grant_q <= 2'b01;
`ifdef WB_ARB_ROUND_ROBIN_EN
            last_m1 <= 1'b0;
`endif
          end else if (pick1) begin
            state   <= GRANT_M1;
            grant_q <= 2'b10;
`ifdef WB_ARB_ROUND_ROBIN_EN
            last_m1 <= 1'b1;
`endif
          end
        end
        GRANT_M0, GRANT_M1: begin
          if (release_ok) begin
            state   <= IDLE;
            grant_q <= 2'b00;
            outst   <= '0;
          end else if (accept & ~retire) begin
            outst <= outst + OUTST_W'(1);
          end else if (retire & ~accept) begin
            outst <= outst - OUTST_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= 2'b00;
          outst   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus randomized masters/slave,
// checked every cycle against a transaction-level ownership model.
module tb_wb_arbiter;

  localparam int OW   = 2;
  localparam int MAXO = 3;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;

  logic [1:0][31:0] adr, wdat, mdat;
  logic [1:0][3:0]  sel;
  logic [1:0]       we, stb, cyc, mack, mstall;

  logic [31:0] s_adr, s_dat_w, s_dat_r;
  logic [3:0]  s_sel;
  logic        s_we, s_stb, s_cyc, s_ack, s_stall;
  logic [1:0]  grant;

  int n_chk = 0;
  int n_fail = 0;

  // model: who owns the bus, strobes owed an ack, last winner (0=m0,1=m1)
  int owner = 0;
  int outst = 0;
  int last = 1;

  // observations taken at the negedge, consumed by the stimulus
  bit [1:0] acc, ackd;
  bit       s_acc;

  always #5 clk = ~clk;

  wb_arbiter #(.OUTST_W(OW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_we_i(we[0]),
    .m0_sel_i(sel[0]), .m0_stb_i(stb[0]), .m0_cyc_i(cyc[0]),
    .m0_dat_o(mdat[0]), .m0_ack_o(mack[0]), .m0_stall_o(mstall[0]),
    .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_we_i(we[1]),
    .m1_sel_i(sel[1]), .m1_stb_i(stb[1]), .m1_cyc_i(cyc[1]),
    .m1_dat_o(mdat[1]), .m1_ack_o(mack[1]), .m1_stall_o(mstall[1]),
    .s_adr_o(s_adr), .s_dat_o(s_dat_w), .s_we_o(s_we),
    .s_sel_o(s_sel), .s_stb_o(s_stb), .s_cyc_o(s_cyc),
    .s_dat_i(s_dat_r), .s_ack_i(s_ack), .s_stall_i(s_stall),
    .grant_o(grant)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ownership model advances on each clock edge
  always @(posedge clk) begin
    int x;
    bit full, sacc, sack;
    if (!rst_ni) begin
      owner = 0;
      outst = 0;
      last = 1;
    end else if (owner == 0) begin
      if (cyc[0] && cyc[1]) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
        owner = (last == 1) ? 1 : 2;
`else
        owner = 1;
`endif
      end else if (cyc[0]) owner = 1;
      else if (cyc[1]) owner = 2;
      if (owner != 0) last = owner - 1;
    end else begin
      x = owner - 1;
      full = (outst == MAXO);
      sacc = stb[x] && !full && !s_stall;
      sack = s_ack && (outst > 0);
      if (!cyc[x] && (outst == 0 || (outst == 1 && s_ack))) begin
        owner = 0;
        outst = 0;
      end else begin
        outst = outst + int'(sacc) - int'(sack);
      end
    end
  end

  // compare every cycle, mid-cycle
  always @(negedge clk) begin
    int eo, x;
    bit full;
    logic [31:0] e_adr, e_dat, e_sdat;
    logic e_we, e_stb, e_cyc, e_stall, e_ack;
    logic [3:0] e_sel;
    logic [1:0] e_gnt;
    eo = rst_ni ? owner : 0;
    x = (eo == 0) ? 0 : eo - 1;
    full = (eo != 0) && (outst == MAXO);
    e_gnt = (eo == 1) ? 2'b01 : ((eo == 2) ? 2'b10 : 2'b00);
    e_adr = (eo != 0) ? adr[x] : 32'h0;
    e_dat = (eo != 0) ? wdat[x] : 32'h0;
    e_we  = (eo != 0) ? we[x] : 1'b0;
    e_sel = (eo != 0) ? sel[x] : 4'h0;
    e_stb = (eo != 0) && stb[x] && !full;
    e_cyc = (eo != 0) && (cyc[x] || outst > 0);
    chk("grant", 32'(grant), 32'(e_gnt));
    chk("s_adr", s_adr, e_adr);
    chk("s_dat", s_dat_w, e_dat);
    chk("s_we", 32'(s_we), 32'(e_we));
    chk("s_sel", 32'(s_sel), 32'(e_sel));
    chk("s_stb", 32'(s_stb), 32'(e_stb));
    chk("s_cyc", 32'(s_cyc), 32'(e_cyc));
    for (int m = 0; m < 2; m++) begin
      if (eo == m + 1) begin
        e_stall = s_stall || full;
        e_ack = s_ack;
        e_sdat = s_dat_r;
      end else begin
        e_stall = 1'b1;
        e_ack = 1'b0;
        e_sdat = 32'h0;
      end
      chk($sformatf("m%0d_stall", m), 32'(mstall[m]), 32'(e_stall));
      chk($sformatf("m%0d_ack", m), 32'(mack[m]), 32'(e_ack));
      chk($sformatf("m%0d_dat", m), mdat[m], e_sdat);
      acc[m] = stb[m] && !mstall[m];
      ackd[m] = mack[m];
    end
    s_acc = s_stb && !s_stall;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    cyc = '0; stb = '0; we = '0; sel = '0;
    adr = '0; wdat = '0;
    s_ack = 1'b0; s_stall = 1'b0; s_dat_r = 32'h0;
  endtask

  int to_issue[2], pend[2], cool[2];
  bit drop_early[2];
  int spend;

  task automatic new_req(input int m);
    adr[m] = $urandom & 32'hFFFF_FFFC;
    wdat[m] = $urandom;
    we[m] = 1'($urandom_range(0, 1));
    sel[m] = 4'($urandom_range(0, 15));
  endtask

  task automatic rand_cycle();
    step();
    for (int m = 0; m < 2; m++) begin
      if (cyc[m]) begin
        if (ackd[m] && pend[m] > 0) pend[m]--;
        if (acc[m]) begin
          to_issue[m]--;
          pend[m]++;
        end
        if (to_issue[m] > 0) begin
          stb[m] = 1'b1;
          if (acc[m]) new_req(m);
        end else begin
          stb[m] = 1'b0;
          if (pend[m] == 0 || drop_early[m]) begin
            cyc[m] = 1'b0;
            pend[m] = 0;
            cool[m] = $urandom_range(0, 3);
          end
        end
      end else if (cool[m] > 0) begin
        cool[m]--;
      end else if ($urandom_range(0, 2) == 0) begin
        cyc[m] = 1'b1;
        stb[m] = 1'b1;
        to_issue[m] = $urandom_range(1, 5);
        drop_early[m] = ($urandom_range(0, 3) == 0);
        new_req(m);
      end
    end
    if (s_acc) spend++;
    if (s_ack && spend > 0) spend--;
    s_stall = ($urandom_range(0, 3) == 0);
    s_dat_r = $urandom;
    s_ack = (spend > 0) && ($urandom_range(0, 1) == 1);
    if (spend == 0 && owner == 0 && $urandom_range(0, 7) == 0)
      s_ack = 1'b1;
  endtask

  initial begin
    idle_all();
    repeat (3) step();
    rst_ni = 1'b1;

    // m0 single read
    step();
    cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h0000_1000;
    #1 chk("t1 grant idle", 32'(grant), 32'h0);
    chk("t1 m0 stall idle", 32'(mstall[0]), 32'h1);
    step(); #1;
    chk("t1 grant m0", 32'(grant), 32'h1);
    chk("t1 s_adr", s_adr, 32'h0000_1000);
    chk("t1 m0 stall", 32'(mstall[0]), 32'h0);
    step();
    stb[0] = 1'b0; s_ack = 1'b1; s_dat_r = 32'hDEAD_BEEF;
    #1 chk("t1 m0 ack", 32'(mack[0]), 32'h1);
    chk("t1 m0 dat", mdat[0], 32'hDEAD_BEEF);
    chk("t1 m1 stall", 32'(mstall[1]), 32'h1);
    step();
    cyc[0] = 1'b0; s_ack = 1'b0;
    #1 chk("t1 grant held", 32'(grant), 32'h1);
    step(); #1;
    chk("t1 grant released", 32'(grant), 32'h0);

    // simultaneous requests from reset
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    cyc = 2'b11; stb = 2'b11;
    adr[0] = 32'h0000_2000; adr[1] = 32'h0000_3000;
    step(); #1;
    chk("t2 grant m0", 32'(grant), 32'h1);
    chk("t2 s_adr m0", s_adr, 32'h0000_2000);
    chk("t2 m1 stall", 32'(mstall[1]), 32'h1);
    step();
    stb[0] = 1'b0; cyc[0] = 1'b0; s_ack = 1'b1; s_dat_r = 32'h1234_5678;
    step();
    s_ack = 1'b0;
    #1 chk("t2 dead cycle", 32'(grant), 32'h0);
    chk("t2 s_adr idle", s_adr, 32'h0);
    step(); #1;
    chk("t2 grant m1", 32'(grant), 32'h2);
    chk("t2 s_adr m1", s_adr, 32'h0000_3000);
    step();
    stb[1] = 1'b0; cyc[1] = 1'b0; s_ack = 1'b1;
    #1 chk("t2 m1 ack", 32'(mack[1]), 32'h1);
    step();
    s_ack = 1'b0;

    // m0 abandons cyc with two acks owed
    step();
    cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h0000_4000;
    repeat (3) step();
    stb[0] = 1'b0; cyc[0] = 1'b0;
    #1 chk("t4 s_cyc held", 32'(s_cyc), 32'h1);
    chk("t4 grant held", 32'(grant), 32'h1);
    step();
    s_ack = 1'b1;
    #1 chk("t4 late ack", 32'(mack[0]), 32'h1);
    step(); #1;
    chk("t4 s_cyc last", 32'(s_cyc), 32'h1);
    step();
    s_ack = 1'b0;
    #1 chk("t4 released", 32'(grant), 32'h0);
    chk("t4 s_cyc off", 32'(s_cyc), 32'h0);

    // counter saturation with acks withheld
    cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 32'h0000_5000;
    repeat (4) step();
    #1 chk("t5 full stall", 32'(mstall[1]), 32'h1);
    chk("t5 full stb", 32'(s_stb), 32'h0);
    step(); #1;
    chk("t5 still full", 32'(mstall[1]), 32'h1);
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    #1 chk("t5 unstall", 32'(mstall[1]), 32'h0);
    chk("t5 stb again", 32'(s_stb), 32'h1);

    // reset in the middle of a grant
    rst_ni = 1'b0;
    #1 chk("t6 rst s_cyc", 32'(s_cyc), 32'h0);
    chk("t6 rst grant", 32'(grant), 32'h0);
    chk("t6 rst m1 stall", 32'(mstall[1]), 32'h1);
    idle_all();
    step();
    rst_ni = 1'b1;

    for (int m = 0; m < 2; m++) begin
      to_issue[m] = 0; pend[m] = 0; cool[m] = 0; drop_early[m] = 1'b0;
    end
    spend = 0;
    repeat (4000) rand_cycle();

    idle_all();
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
